// File: rtl/dice_pkg.sv
// dice_pkg: shared state encoding and verdict codes for the dice player
package dice_pkg;
    typedef enum logic [3:0] {
        IDLE, CLR, GAP, ROLL_R, REL_R, ROLL_L, REL_L, SETTLE, SAMPLE
    } ply_state_t;
    localparam logic [2:0] D_LOSE = 3'b100;
    localparam logic [2:0] D_DRAW = 3'b010;
    localparam logic [2:0] D_WIN  = 3'b001;
    localparam int SETTLE_CYC = 2;
endpackage

// File: rtl/dice_player_hold_timer.sv
// hold_timer: loadable down-counter, expired while the count reads 1
module hold_timer #(
    parameter int HOLD_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              en,
    input  logic [HOLD_W-1:0] value,
    output logic              expired
);
    logic [HOLD_W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (reset) cnt <= '0;
        else if (load) cnt <= value;
        else if (en && cnt != '0) cnt <= cnt - 1'b1;
    end
    assign expired = cnt == HOLD_W'(1);
endmodule

// File: rtl/dice_player.sv
// dice_player: drives ER/EL for programmed hold times and tallies game verdicts
module dice_player
    import dice_pkg::*;
#(
    parameter int HOLD_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [HOLD_W-1:0] hold_r,
    input  logic [HOLD_W-1:0] hold_l,
    input  logic [2:0]        D_in,
    input  logic [3:0]        SUM_in,
    output logic              game_clr,
    output logic              ER,
    output logic              EL,
    output logic              busy,
    output logic              done,
    output logic [3:0]        last_sum,
    output logic [2:0]        last_d,
    output logic [CNT_W-1:0]  wins,
    output logic [CNT_W-1:0]  draws,
    output logic [CNT_W-1:0]  losses,
    output logic [CNT_W-1:0]  errs
);
    ply_state_t        state;
    logic [HOLD_W-1:0] hr, hl, t_val;
    logic              t_load, t_en, t_exp;
    // the timer also paces SETTLE, loaded with SETTLE_CYC on leaving REL_L
    always_comb begin
        t_load = state inside {GAP, REL_R, REL_L};
        t_en   = state inside {ROLL_R, ROLL_L, SETTLE};
        t_val  = state == GAP ? hr : state == REL_R ? hl : HOLD_W'(SETTLE_CYC);
    end
    hold_timer #(.HOLD_W(HOLD_W)) u_timer (
        .clk(clk), .reset(reset), .load(t_load), .en(t_en), .value(t_val), .expired(t_exp)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            hr       <= '0;
            hl       <= '0;
            game_clr <= 1'b0;
            ER       <= 1'b0;
            EL       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            last_sum <= '0;
            last_d   <= '0;
            wins     <= '0;
            draws    <= '0;
            losses   <= '0;
            errs     <= '0;
        end else begin
            game_clr <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state    <= CLR;
                    hr       <= hold_r == '0 ? HOLD_W'(1) : hold_r;
                    hl       <= hold_l == '0 ? HOLD_W'(1) : hold_l;
                    game_clr <= 1'b1;
                    busy     <= 1'b1;
                end
                CLR: state <= GAP;
                GAP: begin
                    state <= ROLL_R;
                    ER    <= 1'b1;
                end
                ROLL_R: if (t_exp) begin
                    state <= REL_R;
                    ER    <= 1'b0;
                end
                REL_R: begin
                    state <= ROLL_L;
                    EL    <= 1'b1;
                end
                ROLL_L: if (t_exp) begin
                    state <= REL_L;
                    EL    <= 1'b0;
                end
                REL_L: state <= SETTLE;
                SETTLE: if (t_exp) begin
                    state <= SAMPLE;
                    done  <= 1'b1;
                end
                SAMPLE: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    last_d   <= D_in;
                    last_sum <= SUM_in;
                    if (D_in == D_WIN) wins <= wins + CNT_W'(wins != '1);
                    else if (D_in == D_DRAW) draws <= draws + CNT_W'(draws != '1);
                    else if (D_in == D_LOSE) losses <= losses + CNT_W'(losses != '1);
                    else errs <= errs + CNT_W'(errs != '1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
